fifo_pkt_reader: RTL and testbench
==================================

// Module: fifo_pkt_reader
// PURPOSE
//  Read-side consumer of the packet fifo: pops words via next_data, checks sop/eop framing,
//  writes payload into SRAM at a wrapping write pointer and emits one descriptor per packet
//  (base, length, error). Sits between the fifo read port and the sram_ctl write port.
// PARAMETERS
//  DATA_WIDTH   16  fifo word / SRAM word width
//  ADDR_WIDTH   10  SRAM word address width; write pointer wraps modulo 2**ADDR_WIDTH
//  MAX_PKT_LEN  64  max words stored per packet; longer packets are truncated
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           asynchronous, active-low reset
//  ready         in   1           fifo holds >=1 word
//  overflow      in   1           fifo overflow flag
//  sop/eop/vld   in   1 each      fifo read framing, valid 1 cycle after next_data
//  out_data      in   DATA_WIDTH  fifo read word, qualified by vld
//  next_data     out  1           1-cycle pop request to fifo
//  sram_busy     in   1           SRAM cannot accept a write this cycle
//  sram_wr_en    out  1           SRAM write request, held until accepted (!sram_busy)
//  sram_addr     out  ADDR_WIDTH  SRAM write address
//  sram_wdata    out  DATA_WIDTH  SRAM write data
//  pkt_done      out  1           1-cycle descriptor strobe
//  pkt_base      out  ADDR_WIDTH  address of first word of packet
//  pkt_len       out  7 ($clog2(MAX_PKT_LEN)+1)  words stored (1..MAX_PKT_LEN)
//  pkt_err       out  1           packet aborted/truncated
//  ovf_seen      out  1           sticky: overflow observed since reset
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, write pointer 0, FSM IDLE, no read outstanding.
//  - Pop rule: next_data=1 only if ready & no read outstanding & !(sram_wr_en & sram_busy)
//    & state!=DONE; max one pop per 2 cycles. Response (vld) sampled exactly 1 cycle later;
//    vld=0 in that cycle clears outstanding, no state change.
//  - Write stage: registered; word sampled with vld -> sram_wr_en=1 next cycle with
//    sram_addr=wr_ptr, sram_wdata=out_data; wr_ptr++ (wrap) on accept (sram_wr_en & !sram_busy).
//  - FSM: IDLE -> (vld&sop) HEAD: pkt_base=wr_ptr, len=1, store; eop same word -> DONE else BODY.
//    IDLE, vld&!sop: word discarded, nothing written, stay IDLE.
//    BODY, vld&!sop: store, len++; eop -> DONE. len==MAX_PKT_LEN before eop -> DROP.
//    BODY, vld&sop: abort current (descriptor with pkt_err=1, len so far), this word starts new pkt.
//    DROP: discard words until eop, then DONE with pkt_err=1, len=MAX_PKT_LEN.
//    DONE: pkt_done=1 for 1 cycle, aligned with acceptance of last stored word's write
//      (same cycle as accept, or next cycle for DROP); -> IDLE.
//  - Abort-by-sop takes priority: aborted descriptor issued before new packet's descriptor;
//    both never share a cycle.
//  - ovf_seen set on overflow=1, cleared only by reset; no effect on FSM.
//  - Reset mid-packet: partial packet not reported, no further SRAM writes.
// STRUCTURE
//  - sram_ctl_pkg: DATA_WIDTH/ADDR_WIDTH defaults, rd_state_t enum {IDLE,BODY,DROP,DONE}.
//  - No sub-module; FSM, pointer, length counter and write register in this file.
// TESTING
//  1 rst=0 then 1, ready=0 -> all outputs 0 for 10 cycles, no next_data.
//  2 4-word pkt A0..A3, sram_busy=0 -> addr 0..3 written, pkt_done base=0 len=4 err=0.
//  3 1-word pkt (sop&eop) after test2 -> addr 4 written, pkt_done base=4 len=1 err=0.
//  4 sram_busy=1 for 5 cycles mid-packet -> sram_wr_en/addr/data held, no next_data,
//    packet completes intact after release.
//  5 70-word pkt -> 64 writes, pkt_done len=64 err=1; sop mid-pkt after 3 words ->
//    desc len=3 err=1, then new pkt from that word.
//  6 wr_ptr=1022, 4-word pkt -> addrs 1022,1023,0,1, base=1022; overflow pulse -> ovf_seen=1.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared defaults and read-side FSM encoding for the packet fifo -> SRAM path.
package sram_ctl_pkg;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int MAX_PKT_LEN_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2,
        DONE = 2'd3
    } rd_state_t;
endpackage

// File: rtl/fifo_pkt_reader.sv
// Pops framed words from the packet fifo, stores payload at a wrapping SRAM pointer
// and emits one descriptor (base, length, error) per packet.
module fifo_pkt_reader
    import sram_ctl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
    localparam int LEN_W      = $clog2(MAX_PKT_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic                  overflow,
    input  logic                  sop,
    input  logic                  eop,
    input  logic                  vld,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  next_data,
    input  logic                  sram_busy,
    output logic                  sram_wr_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  pkt_done,
    output logic [ADDR_WIDTH-1:0] pkt_base,
    output logic [LEN_W-1:0]      pkt_len,
    output logic                  pkt_err,
    output logic                  ovf_seen
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    rd_state_t             state_reg, state_next;
    logic                  active_reg, outstanding_reg, wr_en_reg;
    logic                  abort_pend_reg, err_reg, ovf_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, base_reg, abt_base_reg;
    logic [LEN_W-1:0]      len_reg, abt_len_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic             word_vld, accept, stall, done_fire;
    logic             store, head, abort, grow;
    logic [LEN_W-1:0] len_inc;

    assign word_vld  = vld & outstanding_reg;
    assign accept    = wr_en_reg & ~sram_busy;
    assign stall     = wr_en_reg & sram_busy;
    assign len_inc   = len_reg + 1'b1;
    // An aborted descriptor owns its cycle; the following packet's strobe waits.
    assign done_fire = (state_reg == DONE) & ~abort_pend_reg & ~stall;

    assign next_data = active_reg & ready & ~outstanding_reg & ~stall & (state_reg != DONE);

    always_comb begin
        state_next = state_reg;
        store      = 1'b0;
        head       = 1'b0;
        abort      = 1'b0;
        grow       = 1'b0;
        case (state_reg)
            IDLE, BODY, DROP: begin
                if (word_vld && sop) begin
                    abort = (state_reg != IDLE);
                    head  = 1'b1;
                    store = 1'b1;
                    if (eop)                  state_next = DONE;
                    else if (ONE_LEN == MAX_LEN) state_next = DROP;
                    else                      state_next = BODY;
                end else if (word_vld && state_reg == BODY) begin
                    store = 1'b1;
                    grow  = 1'b1;
                    if (eop)                  state_next = DONE;
                    else if (len_inc == MAX_LEN) state_next = DROP;
                end else if (word_vld && state_reg == DROP && eop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (done_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            active_reg      <= 1'b0;
            outstanding_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            abort_pend_reg  <= 1'b0;
            err_reg         <= 1'b0;
            ovf_reg         <= 1'b0;
            wr_ptr_reg      <= '0;
            base_reg        <= '0;
            abt_base_reg    <= '0;
            len_reg         <= '0;
            abt_len_reg     <= '0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            active_reg      <= 1'b1;
            outstanding_reg <= next_data;
            ovf_reg         <= ovf_reg | overflow;
            abort_pend_reg  <= abort;
            if (abort) begin
                abt_base_reg <= base_reg;
                abt_len_reg  <= len_reg;
            end
            if (head) begin
                base_reg <= wr_ptr_reg;
                len_reg  <= ONE_LEN;
            end else if (grow) begin
                len_reg <= len_inc;
            end
            if (head)                    err_reg <= (state_next == DROP);
            else if (state_next == DROP) err_reg <= 1'b1;
            // Pop gating guarantees the write register is free whenever a word lands.
            if (store) begin
                wr_en_reg <= 1'b1;
                wdata_reg <= out_data;
            end else if (accept) begin
                wr_en_reg <= 1'b0;
            end
            if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
    end

    assign sram_wr_en = wr_en_reg;
    assign sram_addr  = wr_ptr_reg;
    assign sram_wdata = wdata_reg;
    assign pkt_done   = abort_pend_reg | done_fire;
    assign pkt_base   = abort_pend_reg ? abt_base_reg : base_reg;
    assign pkt_len    = abort_pend_reg ? abt_len_reg : len_reg;
    assign pkt_err    = abort_pend_reg | err_reg;
    assign ovf_seen   = ovf_reg;
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench: fifo model answers pops, monitor logs SRAM writes and descriptors.
module tb_fifo_pkt_reader;
    logic        clk = 1'b0, rst = 1'b0, ready = 1'b0, overflow = 1'b0;
    logic        sop = 1'b0, eop = 1'b0, vld = 1'b0, sram_busy = 1'b0;
    logic [15:0] out_data = '0;
    logic        next_data, sram_wr_en, pkt_done, pkt_err, ovf_seen;
    logic [9:0]  sram_addr, pkt_base;
    logic [15:0] sram_wdata;
    logic [6:0]  pkt_len;

    typedef struct packed {logic [9:0] addr; logic [15:0] data;} wr_t;
    typedef struct packed {
        logic [9:0] base; logic [6:0] len; logic err; logic acc; logic [9:0] acc_addr;
    } desc_t;

    logic [17:0] fifo_q[$];
    wr_t         wr_q[$];
    desc_t       desc_q[$];
    int          checks = 0, errors = 0, wi = 0, di = 0;

    always #5 clk = ~clk;

    fifo_pkt_reader dut (
        .clk(clk), .rst(rst), .ready(ready), .overflow(overflow),
        .sop(sop), .eop(eop), .vld(vld), .out_data(out_data),
        .next_data(next_data), .sram_busy(sram_busy), .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .pkt_done(pkt_done),
        .pkt_base(pkt_base), .pkt_len(pkt_len), .pkt_err(pkt_err), .ovf_seen(ovf_seen)
    );

    // Fifo read port: a pop seen in one cycle is answered with vld in the next.
    initial begin : fifo_model
        logic        pop_req;
        logic [17:0] w;
        w = '0;
        forever begin
            @(negedge clk);
            pop_req = next_data && (fifo_q.size() != 0);
            if (pop_req) w = fifo_q.pop_front();
            @(posedge clk);
            #1;
            vld      = pop_req;
            sop      = pop_req & w[17];
            eop      = pop_req & w[16];
            out_data = pop_req ? w[15:0] : 16'h0;
            ready    = (fifo_q.size() != 0);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sram_wr_en && !sram_busy) wr_q.push_back({sram_addr, sram_wdata});
                if (pkt_done)
                    desc_q.push_back({pkt_base, pkt_len, pkt_err, sram_wr_en && !sram_busy, sram_addr});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic s, input logic e, input logic [15:0] d);
        fifo_q.push_back({s, e, d});
    endtask

    task automatic push_pkt(input int n, input logic [15:0] d0);
        for (int i = 0; i < n; i++) push_word(i == 0, i == n - 1, d0 + 16'(i));
    endtask

    task automatic wait_desc(input string tag, input int n, input int budget);
        int c = 0;
        while (desc_q.size() < n && c < budget) begin
            cyc();
            c++;
        end
        chk(tag, 64'(desc_q.size() >= n), 64'd1);
    endtask

    task automatic check_wr(input string tag, input logic [9:0] a, input logic [15:0] d);
        wr_t w = (wi < wr_q.size()) ? wr_q[wi] : '0;
        chk(tag, 64'(w), 64'({a, d}));
        wi++;
    endtask

    task automatic check_desc(input string tag, input logic [9:0] b, input logic [6:0] l, input logic e);
        desc_t d = (di < desc_q.size()) ? desc_q[di] : '0;
        chk(tag, 64'({d.base, d.len, d.err}), 64'({b, l, e}));
        di++;
    endtask

    // Descriptor strobe must coincide with acceptance of the packet's last write.
    task automatic check_acc(input string tag, input logic [9:0] a);
        desc_t d = (di > 0 && di <= desc_q.size()) ? desc_q[di-1] : '0;
        chk(tag, 64'({d.acc, d.acc_addr}), 64'({1'b1, a}));
    endtask

    initial begin : stim
        logic found;
        int   nwr, nd;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 64'({next_data, sram_wr_en, sram_addr, sram_wdata, pkt_done,
                               pkt_base, pkt_len, pkt_err, ovf_seen}), 64'd0);
        cyc();
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_outs", 64'({next_data, sram_wr_en, sram_addr, sram_wdata, pkt_done,
                                  pkt_base, pkt_len, pkt_err, ovf_seen}), 64'd0);
        end

        cyc();
        push_pkt(4, 16'hA000);
        wait_desc("t2_timeout", 1, 200);
        for (int i = 0; i < 4; i++) check_wr("t2_wr", 10'(i), 16'hA000 + 16'(i));
        check_desc("t2_desc", 10'd0, 7'd4, 1'b0);
        check_acc("t2_align", 10'd3);

        push_word(1'b1, 1'b1, 16'hB000);
        wait_desc("t3_timeout", 2, 100);
        check_wr("t3_wr", 10'd4, 16'hB000);
        check_desc("t3_desc", 10'd4, 7'd1, 1'b0);
        check_acc("t3_align", 10'd4);

        push_pkt(6, 16'hC000);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            cyc();
            if (sram_wr_en && sram_addr == 10'd7) found = 1'b1;
        end
        chk("t4_reach", 64'(found), 64'd1);
        sram_busy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold", 64'({sram_wr_en, sram_addr, sram_wdata, next_data, pkt_done}),
                64'({1'b1, 10'd7, 16'hC002, 1'b0, 1'b0}));
            cyc();
        end
        sram_busy = 1'b0;
        wait_desc("t4_timeout", 3, 200);
        for (int i = 0; i < 6; i++) check_wr("t4_wr", 10'(5 + i), 16'hC000 + 16'(i));
        check_desc("t4_desc", 10'd5, 7'd6, 1'b0);
        check_acc("t4_align", 10'd10);

        push_pkt(70, 16'hD000);
        wait_desc("t5_timeout", 4, 400);
        chk("t5_wr_count", 64'(wr_q.size() - wi), 64'd64);
        for (int i = 0; i < 64; i++) check_wr("t5_wr", 10'(11 + i), 16'hD000 + 16'(i));
        check_desc("t5_desc", 10'd11, 7'd64, 1'b1);

        push_word(1'b1, 1'b0, 16'hE000);
        push_word(1'b0, 1'b0, 16'hE001);
        push_word(1'b0, 1'b0, 16'hE002);
        push_pkt(3, 16'hF000);
        wait_desc("t5b_timeout", 6, 200);
        for (int i = 0; i < 3; i++) check_wr("t5b_wr_e", 10'(75 + i), 16'hE000 + 16'(i));
        for (int i = 0; i < 3; i++) check_wr("t5b_wr_f", 10'(78 + i), 16'hF000 + 16'(i));
        check_desc("t5b_abort", 10'd75, 7'd3, 1'b0 | 1'b1);
        check_desc("t5b_new", 10'd78, 7'd3, 1'b0);
        check_acc("t5b_align", 10'd80);

        for (int p = 0; p < 14; p++) push_pkt(64, 16'h1000 + 16'(p * 64));
        push_pkt(45, 16'h2000);
        wait_desc("t6_fill_timeout", 21, 6000);
        di = 20;
        check_desc("t6_fill_desc", 10'd977, 7'd45, 1'b0);
        chk("t6_fill_count", 64'(wr_q.size()), 64'd1022);
        wi = 1022;
        push_pkt(4, 16'h6000);
        wait_desc("t6_timeout", 22, 100);
        check_wr("t6_wr0", 10'd1022, 16'h6000);
        check_wr("t6_wr1", 10'd1023, 16'h6001);
        check_wr("t6_wr2", 10'd0, 16'h6002);
        check_wr("t6_wr3", 10'd1, 16'h6003);
        check_desc("t6_desc", 10'd1022, 7'd4, 1'b0);
        check_acc("t6_align", 10'd1);

        @(negedge clk);
        chk("ovf_pre", 64'(ovf_seen), 64'd0);
        cyc();
        overflow = 1'b1;
        cyc();
        overflow = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("ovf_sticky", 64'(ovf_seen), 64'd1);

        push_pkt(5, 16'h7000);
        nwr = wr_q.size();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            cyc();
            if (wr_q.size() >= nwr + 2) found = 1'b1;
        end
        chk("rst_mid_reach", 64'(found), 64'd1);
        rst = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        chk("rst_mid_outs", 64'({next_data, sram_wr_en, sram_addr, sram_wdata, pkt_done,
                                 pkt_base, pkt_len, pkt_err, ovf_seen}), 64'd0);
        cyc();
        rst = 1'b1;
        nwr = wr_q.size();
        nd  = desc_q.size();
        repeat (10) cyc();
        chk("rst_mid_quiet", 64'({wr_q.size() == nwr, desc_q.size() == nd}), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
